// File: rtl/w_clk_module.sv
// -----------------------------------------------------------------------------
// w_clk_module
// Write-side control stage of an asynchronous FIFO. Everything in this block
// runs on w_clk.
//
// Responsibilities:
//   - Owns the binary write pointer and its Gray image. The Gray image is
//     exported to the read domain.
//   - Drives the dual-port RAM write address and write enable.
//   - Brings the read domain's Gray pointer in through a 2-FF synchroniser.
//   - Produces the full, sticky overflow and (optional) almost-full flags.
//
// Optional feature macro: W_ALMOST_FULL_EN
//   Defined   : builds the Gray-to-binary converter and the fill-level compare
//               that drive w_almost_full.
//   Undefined : none of that logic is built, and w_almost_full is held at 0.
//
// Parameters:
//   ADDRESS_SIZE        RAM address width. FIFO depth is 2**ADDRESS_SIZE.
//                       Pointers are ADDRESS_SIZE+1 bits wide. Must be >= 2.
//   ALMOST_FULL_THRESH  Fill level at or above which w_almost_full asserts.
//
// Ports:
//   w_clk          in   write clock
//   wrst           in   synchronous active-high reset
//   w_en           in   write request from the producer
//   r_ptr          in   Gray read pointer (asynchronous to w_clk)
//   w_ptr          out  registered Gray write pointer, to the read domain
//   w_addr         out  RAM write address (low bits of the binary pointer)
//   w_mem_en       out  RAM write enable (combinational, same-cycle accept)
//   w_full         out  registered full flag
//   w_overflow     out  sticky flag: a write was attempted while full
//   w_almost_full  out  registered almost-full flag
// -----------------------------------------------------------------------------
module w_clk_module #(
   parameter int ADDRESS_SIZE       = 4,
   parameter int ALMOST_FULL_THRESH = (2 ** ADDRESS_SIZE) - 2
) (
   input  logic                    w_clk,
   input  logic                    wrst,
   input  logic                    w_en,
   input  logic [ADDRESS_SIZE:0]   r_ptr,
   output logic [ADDRESS_SIZE:0]   w_ptr,
   output logic [ADDRESS_SIZE-1:0] w_addr,
   output logic                    w_mem_en,
   output logic                    w_full,
   output logic                    w_overflow,
   output logic                    w_almost_full
);

   localparam int A  = ADDRESS_SIZE;
   localparam int PW = ADDRESS_SIZE + 1;

   // The full compare inverts the top two pointer bits, so at least two bits
   // are needed. The threshold must be a reachable fill level.
   if (ADDRESS_SIZE < 2) begin : g_bad_address_size
      $error("w_clk_module: ADDRESS_SIZE must be >= 2");
   end
   if ((ALMOST_FULL_THRESH < 0) || (ALMOST_FULL_THRESH > (2 ** ADDRESS_SIZE))) begin : g_bad_thresh
      $error("w_clk_module: ALMOST_FULL_THRESH must lie in 0..2**ADDRESS_SIZE");
   end

   // State registers and their next-state values.
   logic [A:0] w_bin_q, w_bin_d;   // binary write pointer
   logic [A:0] w_ptr_q, w_ptr_d;   // Gray write pointer, always Gray(w_bin_q)
   logic [A:0] rq1_q;              // first synchroniser stage
   logic [A:0] rq2_q;              // second synchroniser stage
   logic       w_full_q, w_full_d;
   logic       w_ovf_q, w_ovf_d;
   logic       w_af_q, w_af_d;

   // Combinational helpers.
   logic       w_inc_s;            // a write is accepted this cycle
   logic [A:0] full_cmp_s;         // Gray value the write pointer has when full

`ifdef W_ALMOST_FULL_EN
   localparam logic [A:0] THRESH_C = PW'(ALMOST_FULL_THRESH);

   logic [A:0] wq2_rbin_s;         // synchronised read pointer, in binary
   logic [A:0] w_level_s;          // fill level after this cycle's write

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [A:0] gray2bin(input logic [A:0] g);
      logic [A:0] b;
      b[A] = g[A];
      for (int i = A - 1; i >= 0; i--) begin
         b[i] = b[i + 1] ^ g[i];
      end
      return b;
   endfunction
`endif

   // Accept logic, pointer next-state, and full/overflow/almost-full next-state.
   always_comb begin
      // Reset wins over a simultaneous request, and a full FIFO drops the write.
      w_inc_s = w_en & ~w_full_q & ~wrst;

      w_bin_d = w_bin_q + {{A{1'b0}}, w_inc_s};
      w_ptr_d = w_bin_d ^ (w_bin_d >> 1);

      // The FIFO is full when the write pointer is exactly one lap ahead of
      // the read pointer. In Gray code that means the two MSBs differ and
      // the remaining bits match. The compare uses the post-write pointer,
      // so full rises on the same edge that fills the last slot.
      full_cmp_s = {~rq2_q[A:A-1], rq2_q[A-2:0]};
      w_full_d   = (w_ptr_d == full_cmp_s);

      // Sticky until reset.
      w_ovf_d = w_ovf_q | (w_en & w_full_q);

`ifdef W_ALMOST_FULL_EN
      // The subtraction wraps modulo 2**(A+1). Because the read pointer is
      // stale, the level can only be over-estimated, so the flag is
      // pessimistic.
      wq2_rbin_s = gray2bin(rq2_q);
      w_level_s  = w_bin_d - wq2_rbin_s;
      w_af_d     = (w_level_s >= THRESH_C);
`else
      w_af_d = 1'b0;
`endif
   end

   // All w_clk state: pointers, synchroniser, and status flags.
   always_ff @(posedge w_clk) begin
      if (wrst) begin
         w_bin_q  <= '0;
         w_ptr_q  <= '0;
         rq1_q    <= '0;
         rq2_q    <= '0;
         w_full_q <= 1'b0;
         w_ovf_q  <= 1'b0;
         w_af_q   <= 1'b0;
      end else begin
         w_bin_q  <= w_bin_d;
         w_ptr_q  <= w_ptr_d;
         rq1_q    <= r_ptr;
         rq2_q    <= rq1_q;
         w_full_q <= w_full_d;
         w_ovf_q  <= w_ovf_d;
         w_af_q   <= w_af_d;
      end
   end

   assign w_ptr         = w_ptr_q;
   assign w_addr        = w_bin_q[A-1:0];
   assign w_mem_en      = w_inc_s;
   assign w_full        = w_full_q;
   assign w_overflow    = w_ovf_q;
   assign w_almost_full = w_af_q;

endmodule

// File: tb/tb_w_clk_module.sv
// -----------------------------------------------------------------------------
// tb_w_clk_module
// Self-checking bench for w_clk_module with ADDRESS_SIZE=3 (depth 8) and
// ALMOST_FULL_THRESH=6. Each cycle's expected outputs are queued when the
// stimulus is driven:
//   - w_mem_en is checked before the edge.
//   - The registered outputs are popped and checked just after the edge.
// The almost-full expectation follows W_ALMOST_FULL_EN.
// -----------------------------------------------------------------------------
module tb_w_clk_module;

   localparam int AS = 3;
   localparam int TH = 6;
`ifdef W_ALMOST_FULL_EN
   localparam bit AF_ON = 1'b1;
`else
   localparam bit AF_ON = 1'b0;
`endif

   logic          w_clk;
   logic          wrst;
   logic          w_en;
   logic [AS:0]   r_ptr;
   logic [AS:0]   w_ptr;
   logic [AS-1:0] w_addr;
   logic          w_mem_en;
   logic          w_full;
   logic          w_overflow;
   logic          w_almost_full;

   typedef struct {
      logic          mem_en;
      logic [AS:0]   ptr;
      logic [AS-1:0] addr;
      logic          full;
      logic          ovf;
      logic          af;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec;
   int   n_err;

   w_clk_module #(
      .ADDRESS_SIZE      (AS),
      .ALMOST_FULL_THRESH(TH)
   ) dut (
      .w_clk        (w_clk),
      .wrst         (wrst),
      .w_en         (w_en),
      .r_ptr        (r_ptr),
      .w_ptr        (w_ptr),
      .w_addr       (w_addr),
      .w_mem_en     (w_mem_en),
      .w_full       (w_full),
      .w_overflow   (w_overflow),
      .w_almost_full(w_almost_full)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   function automatic logic [AS:0] gray4(input int n);
      logic [AS:0] b;
      b = n[AS:0];
      return b ^ (b >> 1);
   endfunction

   function automatic exp_t mk(input logic me, input int cnt, input logic f,
                               input logic o, input logic a);
      exp_t e;
      logic [AS:0] b;
      b = cnt[AS:0];
      e.mem_en = me;
      e.ptr    = gray4(cnt);
      e.addr   = b[AS-1:0];
      e.full   = f;
      e.ovf    = o;
      e.af     = a;
      return e;
   endfunction

   // Drive one cycle's inputs at the falling edge and queue its expectation.
   task automatic drive(input logic rst, input logic en, input logic [AS:0] rp,
                        input exp_t e);
      @(negedge w_clk);
      wrst  = rst;
      w_en  = en;
      r_ptr = rp;
      sb_q.push_back(e);
      #1;
   endtask

   task automatic settle();
      @(posedge w_clk);
      #1;
   endtask

   task automatic test_reset(input logic en);
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, en, '0, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
         n_vec++;
         if (w_mem_en !== sb_q[0].mem_en) begin
            n_err++;
            $display("FAIL reset.mem_en cyc%0d got %b want %b", k, w_mem_en, sb_q[0].mem_en);
         end
         settle();
         e = sb_q.pop_front();
         n_vec += 5;
         if (w_ptr !== e.ptr) begin n_err++; $display("FAIL reset.ptr got %b want %b", w_ptr, e.ptr); end
         if (w_addr !== e.addr) begin n_err++; $display("FAIL reset.addr got %0d want %0d", w_addr, e.addr); end
         if (w_full !== e.full) begin n_err++; $display("FAIL reset.full got %b want %b", w_full, e.full); end
         if (w_overflow !== e.ovf) begin n_err++; $display("FAIL reset.ovf got %b want %b", w_overflow, e.ovf); end
         if (w_almost_full !== e.af) begin n_err++; $display("FAIL reset.af got %b want %b", w_almost_full, e.af); end
      end
   endtask

   // Eight writes against an empty read side: the eighth write fills the FIFO.
   task automatic test_fill();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, '0, mk(1'b1, i + 1, (i == 7), 1'b0, AF_ON && ((i + 1) >= TH)));
         n_vec++;
         if (w_mem_en !== sb_q[0].mem_en) begin
            n_err++;
            $display("FAIL fill.mem_en w%0d got %b want %b", i, w_mem_en, sb_q[0].mem_en);
         end
         settle();
         e = sb_q.pop_front();
         n_vec += 5;
         if (w_ptr !== e.ptr) begin n_err++; $display("FAIL fill.ptr w%0d got %b want %b", i, w_ptr, e.ptr); end
         if (w_addr !== e.addr) begin n_err++; $display("FAIL fill.addr w%0d got %0d want %0d", i, w_addr, e.addr); end
         if (w_full !== e.full) begin n_err++; $display("FAIL fill.full w%0d got %b want %b", i, w_full, e.full); end
         if (w_overflow !== e.ovf) begin n_err++; $display("FAIL fill.ovf w%0d got %b want %b", i, w_overflow, e.ovf); end
         if (w_almost_full !== e.af) begin n_err++; $display("FAIL fill.af w%0d got %b want %b", i, w_almost_full, e.af); end
      end
   endtask

   // A write while full is dropped and sets the sticky overflow flag.
   task automatic test_overflow();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, (k == 0), '0, mk(1'b0, 8, 1'b1, 1'b1, AF_ON));
         n_vec++;
         if (w_mem_en !== sb_q[0].mem_en) begin
            n_err++;
            $display("FAIL ovf.mem_en cyc%0d got %b want %b", k, w_mem_en, sb_q[0].mem_en);
         end
         settle();
         e = sb_q.pop_front();
         n_vec += 5;
         if (w_ptr !== e.ptr) begin n_err++; $display("FAIL ovf.ptr cyc%0d got %b want %b", k, w_ptr, e.ptr); end
         if (w_addr !== e.addr) begin n_err++; $display("FAIL ovf.addr cyc%0d got %0d want %0d", k, w_addr, e.addr); end
         if (w_full !== e.full) begin n_err++; $display("FAIL ovf.full cyc%0d got %b want %b", k, w_full, e.full); end
         if (w_overflow !== e.ovf) begin n_err++; $display("FAIL ovf.ovf cyc%0d got %b want %b", k, w_overflow, e.ovf); end
         if (w_almost_full !== e.af) begin n_err++; $display("FAIL ovf.af cyc%0d got %b want %b", k, w_almost_full, e.af); end
      end
   endtask

   // Read pointer advances to Gray(1).
   //   Cycles 0-2: idle. Full holds for two edges and clears on the third.
   //   Cycle 3:    one write to address 0 refills the FIFO.
   //   Cycle 4:    another write attempt while full is dropped.
   task automatic test_full_release();
      exp_t e;
      exp_t tbl[5];
      tbl[0] = mk(1'b0, 8, 1'b1, 1'b1, AF_ON);
      tbl[1] = mk(1'b0, 8, 1'b1, 1'b1, AF_ON);
      tbl[2] = mk(1'b0, 8, 1'b0, 1'b1, AF_ON);
      tbl[3] = mk(1'b1, 9, 1'b1, 1'b1, AF_ON);
      tbl[4] = mk(1'b0, 9, 1'b1, 1'b1, AF_ON);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, (k >= 3), gray4(1), tbl[k]);
         n_vec++;
         if (w_mem_en !== sb_q[0].mem_en) begin
            n_err++;
            $display("FAIL release.mem_en cyc%0d got %b want %b", k, w_mem_en, sb_q[0].mem_en);
         end
         settle();
         e = sb_q.pop_front();
         n_vec += 5;
         if (w_ptr !== e.ptr) begin n_err++; $display("FAIL release.ptr cyc%0d got %b want %b", k, w_ptr, e.ptr); end
         if (w_addr !== e.addr) begin n_err++; $display("FAIL release.addr cyc%0d got %0d want %0d", k, w_addr, e.addr); end
         if (w_full !== e.full) begin n_err++; $display("FAIL release.full cyc%0d got %b want %b", k, w_full, e.full); end
         if (w_overflow !== e.ovf) begin n_err++; $display("FAIL release.ovf cyc%0d got %b want %b", k, w_overflow, e.ovf); end
         if (w_almost_full !== e.af) begin n_err++; $display("FAIL release.af cyc%0d got %b want %b", k, w_almost_full, e.af); end
      end
   endtask

   // Twenty back-to-back writes with the read pointer trailing four writes.
   // The read pointer reaches the DUT's compare two edges after it is driven.
   task automatic test_back_to_back();
      exp_t e;
      int   rp_bin[21];
      int   rq2;
      int   lvl;
      rp_bin[0] = 0;
      for (int j = 1; j <= 20; j++) begin
         rp_bin[j] = ((j - 1) > 4) ? (j - 1 - 4) : 0;
         rq2 = (j >= 3) ? rp_bin[j - 2] : 0;
         lvl = j - rq2;
         drive(1'b0, 1'b1, gray4(rp_bin[j]), mk(1'b1, j, 1'b0, 1'b0, AF_ON && (lvl >= TH)));
         n_vec++;
         if (w_mem_en !== sb_q[0].mem_en) begin
            n_err++;
            $display("FAIL b2b.mem_en w%0d got %b want %b", j, w_mem_en, sb_q[0].mem_en);
         end
         settle();
         e = sb_q.pop_front();
         n_vec += 5;
         if (w_ptr !== e.ptr) begin n_err++; $display("FAIL b2b.ptr w%0d got %b want %b", j, w_ptr, e.ptr); end
         if (w_addr !== e.addr) begin n_err++; $display("FAIL b2b.addr w%0d got %0d want %0d", j, w_addr, e.addr); end
         if (w_full !== e.full) begin n_err++; $display("FAIL b2b.full w%0d got %b want %b", j, w_full, e.full); end
         if (w_overflow !== e.ovf) begin n_err++; $display("FAIL b2b.ovf w%0d got %b want %b", j, w_overflow, e.ovf); end
         if (w_almost_full !== e.af) begin n_err++; $display("FAIL b2b.af w%0d got %b want %b", j, w_almost_full, e.af); end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      wrst  = 1'b1;
      w_en  = 1'b0;
      r_ptr = '0;
      test_reset(1'b1);
      test_fill();
      test_overflow();
      test_full_release();
      // A reset in the middle of traffic (w_en held high) clears overflow.
      test_reset(1'b1);
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/w_clk_module.md
Name: w_clk_module

Overview:
- Write-side control stage of the asynchronous FIFO. It sits upstream of the read-side control and feeds it `w_ptr`.
- Owns the binary/Gray write pointer, the dual-port RAM write address and enable, and full/overflow status.
- Synchronises the read-side Gray pointer `r_ptr` into the `w_clk` domain with a 2-FF synchroniser.
- All logic runs on `w_clk` only.

Parameters:
- ADDRESS_SIZE, 4, RAM address width; FIFO depth = 2^ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.
- ALMOST_FULL_THRESH, 2^ADDRESS_SIZE-2, fill level at or above which w_almost_full asserts (only used with W_ALMOST_FULL_EN).

Ports:
- w_clk  input  1  write clock; all state updates on posedge.
- wrst  input  1  synchronous, active-high reset, sampled on posedge w_clk.
- w_en  input  1  write request from producer.
- r_ptr  input  ADDRESS_SIZE+1  Gray read pointer from the read domain (asynchronous to w_clk).
- w_ptr  output  ADDRESS_SIZE+1  registered Gray write pointer, to the read domain.
- w_addr  output  ADDRESS_SIZE  RAM write address = w_bin[ADDRESS_SIZE-1:0].
- w_mem_en  output  1  RAM write enable (combinational).
- w_full  output  1  registered full flag.
- w_overflow  output  1  sticky flag: a write was attempted while full.
- w_almost_full  output  1  registered almost-full flag (see Optional Feature).

Behaviour:
- Reset (wrst=1 at an edge): w_bin=0, w_ptr=0, both synchroniser stages=0, w_full=0, w_overflow=0, w_almost_full=0. Reset overrides a simultaneous w_en; no write is accepted in that cycle.
- Reset mid-operation: pointers drop to 0 on that edge. The read side must be reset in the same window; this block does not handshake reset.
- Accept condition: w_inc = w_en & !w_full & !wrst. w_mem_en = w_inc, combinational, same cycle. The RAM writes data to w_addr at that edge.
- Pointer next-state:
  - w_bnext = w_bin + w_inc (width ADDRESS_SIZE+1, wraps modulo 2^(ADDRESS_SIZE+1)).
  - w_gnext = w_bnext ^ (w_bnext >> 1).
  - Both w_bin and w_ptr register on the same edge, so w_ptr is always Gray(w_bin); zero added latency.
- Address wrap: w_addr wraps 2^ADDRESS_SIZE-1 -> 0 naturally; the pointer MSB toggles on each wrap.
- Synchroniser: rq2_rptr = r_ptr delayed two w_clk edges. There is no other path from r_ptr into logic.
- Full detection:
  - full_next = (w_gnext == {~rq2_rptr[A:A-1], rq2_rptr[A-2:0]}), where A = ADDRESS_SIZE; requires ADDRESS_SIZE >= 2.
  - w_full <= full_next each edge.
  - Full asserts on the same edge that accepts the write filling the last slot.
  - Deassertion is pessimistic: 3 edges after r_ptr changes (2 sync + 1 flag register).
- No write is ever accepted while w_full=1, so the FIFO never overwrites.
- Overflow: w_overflow <= w_overflow | (w_en & w_full). It is sticky until wrst. The write itself is dropped: w_mem_en=0 and the pointer is unchanged.
- Simultaneous write and read-pointer advance: handled by the registered compare; the synchronised pointer only ever under-estimates free space.

Optional Feature:
- Macro: W_ALMOST_FULL_EN.
- With the macro defined:
  - Gray-to-binary converter on rq2_rptr gives wq2_rbin.
  - w_level = w_bnext - wq2_rbin, modulo 2^(ADDRESS_SIZE+1); range 0..2^ADDRESS_SIZE.
  - w_almost_full <= (w_level >= ALMOST_FULL_THRESH).
  - The flag is pessimistic by the synchroniser lag.
- Without the macro: no converter or level logic is built; w_almost_full is tied 0; the port still exists.

Test Plan:
- ADDRESS_SIZE=3, wrst=1 for 2 edges with w_en=1 -> w_ptr=0000, w_addr=0, w_full=0, w_overflow=0, w_mem_en=0 throughout reset.
- r_ptr=0000, w_en=1 for 8 edges -> w_addr steps 0..7 with w_mem_en=1; after the 8th edge w_full=1, w_ptr=1100 (Gray of 8), w_addr=0.
- While full, w_en=1 one more cycle -> w_mem_en=0, w_ptr stays 1100, w_overflow=1 next edge and stays 1 until wrst.
- While full, set r_ptr=0001 (Gray of 1) -> w_full stays 1 for 2 edges and reads 0 after the 3rd edge; the next write goes to w_addr=0 and w_full reasserts.
- Continuous writes with r_ptr tracking w_ptr (delayed 4 cycles), 20 writes -> w_addr wraps 7->0 twice, w_ptr MSB toggles at counts 8 and 16, w_full never asserts, w_overflow=0.
- W_ALMOST_FULL_EN defined, ALMOST_FULL_THRESH=6, r_ptr=0000, 6 writes -> w_almost_full=1 after the 6th edge and 0 before it. With the macro undefined, the same stimulus gives w_almost_full=0.
